pool_wr_arbiter: RTL and testbench

Round-robin write arbiter and frame sequencer behind the 16-lane pooling array. Each pooling lane emits valid/result/address with no backpressure, so every lane gets a small FIFO. A round-robin arbiter drains the FIFOs onto one shared feature-map SRAM write port, and a frame FSM raises a done pulse once every lane has delivered its last result and all buffers are empty.

---
 rtl/pool_pkg.sv | 22 ++
 rtl/pool_lane_fifo.sv | 55 +++++
 rtl/pool_wr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_pool_wr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and sizing for the pooling-array write arbiter.
package pool_pkg;

  localparam int unsigned POOL_NUM      = 16;
  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned ADDRESS_WIDTH = 10;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned LANE_IDX_W    = $clog2(POOL_NUM);

  typedef struct packed {
    logic                     last;
    logic [DATA_WIDTH-1:0]    data;
    logic [ADDRESS_WIDTH-1:0] addr;
  } pool_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pool_arb_state_t;

endpackage

// File: rtl/pool_lane_fifo.sv
// Per-lane FIFO of pool entries; a push into a full FIFO succeeds only when
// the head is popped in the same cycle, otherwise the new entry is dropped.
module pool_lane_fifo
  import pool_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pool_entry_t din,
  input  logic        pop,
  output pool_entry_t head_c,
  output logic        full_c,
  output logic        empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pool_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pool_wr_arbiter.sv
// Round-robin drain of per-lane result FIFOs onto one SRAM write port, with
// frame sequencing. Define POOL_WR_ARB_OVF_CHECK_EN for the sticky overflow flag.
module pool_wr_arbiter #(
  parameter int unsigned POOL_NUM      = pool_pkg::POOL_NUM,
  parameter int unsigned DATA_WIDTH    = pool_pkg::DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = pool_pkg::ADDRESS_WIDTH,
  parameter int unsigned FIFO_DEPTH    = pool_pkg::FIFO_DEPTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start_i,
  input  logic                                      pool_last_i [POOL_NUM],
  input  logic [POOL_NUM-1:0]                       pool_valid_i,
  input  logic [DATA_WIDTH-1:0]                     pool_result_i [POOL_NUM],
  input  logic [ADDRESS_WIDTH-1:0]                  pool_result_address_i [POOL_NUM],
  output logic                                      wr_valid_o,
  input  logic                                      wr_ready_i,
  output logic [ADDRESS_WIDTH+$clog2(POOL_NUM)-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]                     wr_data_o,
  output logic                                      wr_last_o,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      ovf_o
);

  localparam int unsigned LANE_IDX_W = $clog2(POOL_NUM);

  pool_pkg::pool_entry_t     head_c [POOL_NUM];
  pool_pkg::pool_entry_t     head_sel_c;
  pool_pkg::pool_arb_state_t state;
  pool_pkg::pool_arb_state_t state_nxt;
  logic [POOL_NUM-1:0]       empty_vec;
  logic [POOL_NUM-1:0]       full_vec;
  logic [POOL_NUM-1:0]       last_vec;
  logic [POOL_NUM-1:0]       pop_c;
  logic [POOL_NUM-1:0]       last_seen;
  logic [POOL_NUM-1:0]       last_seen_nxt;
  logic [LANE_IDX_W-1:0]     rr_ptr;
  logic [LANE_IDX_W-1:0]     grant_c;
  logic                      grant_vld_c;
  logic                      load_c;
  logic                      done_c;

  for (genvar i = 0; i < int'(POOL_NUM); i++) begin : g_lane
    assign last_vec[i] = pool_last_i[i];

    pool_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (pool_valid_i[i]),
      .din     ({pool_last_i[i], pool_result_i[i], pool_result_address_i[i]}),
      .pop     (pop_c[i]),
      .head_c  (head_c[i]),
      .full_c  (full_vec[i]),
      .empty_c (empty_vec[i])
    );
  end

  // Round-robin search starting one past the last granted lane.
  always_comb begin : p_arb
    logic [LANE_IDX_W-1:0] idx;
    idx         = '0;
    grant_c     = rr_ptr;
    grant_vld_c = 1'b0;
    for (int k = 1; k <= int'(POOL_NUM); k++) begin
      idx = rr_ptr + LANE_IDX_W'(k);
      if (!grant_vld_c && !empty_vec[idx]) begin
        grant_c     = idx;
        grant_vld_c = 1'b1;
      end
    end
  end

  assign load_c     = !wr_valid_o || wr_ready_i;
  assign head_sel_c = head_c[grant_c];

  always_comb begin
    pop_c = '0;
    if (load_c && grant_vld_c) pop_c[grant_c] = 1'b1;
  end

  // Output register holds steady while a write is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      wr_last_o  <= 1'b0;
      rr_ptr     <= LANE_IDX_W'(POOL_NUM - 1);
    end else if (load_c) begin
      wr_valid_o <= grant_vld_c;
      if (grant_vld_c) begin
        wr_addr_o <= {grant_c, head_sel_c.addr};
        wr_data_o <= head_sel_c.data;
        wr_last_o <= head_sel_c.last;
        rr_ptr    <= grant_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= pool_pkg::IDLE;
      last_seen <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_seen <= last_seen_nxt;
      busy_o    <= (state_nxt != pool_pkg::IDLE);
      done_o    <= done_c;
    end
  end

  // Frame completion is judged on last flags, not on result counts.
  always_comb begin
    state_nxt     = state;
    last_seen_nxt = last_seen;
    done_c        = 1'b0;
    case (state)
      pool_pkg::IDLE: begin
        if (start_i) begin
          state_nxt     = pool_pkg::RUN;
          last_seen_nxt = '0;
        end
      end
      pool_pkg::RUN: begin
        last_seen_nxt = last_seen | (pool_valid_i & last_vec);
        if (&last_seen) state_nxt = pool_pkg::DRAIN;
      end
      pool_pkg::DRAIN: begin
        if ((&empty_vec) && load_c && !(|pool_valid_i)) begin
          state_nxt = pool_pkg::IDLE;
          done_c    = 1'b1;
        end
      end
      default: state_nxt = pool_pkg::IDLE;
    endcase
  end

`ifdef POOL_WR_ARB_OVF_CHECK_EN
  logic [POOL_NUM-1:0] drop_c;

  assign drop_c = pool_valid_i & full_vec & ~pop_c;

  always_ff @(posedge clk) begin
    if (rst) ovf_o <= 1'b0;
    else     ovf_o <= (ovf_o && !start_i) || (|drop_c);
  end

  a_no_drop: assert property (@(posedge clk) disable iff (rst) drop_c == '0)
    else $error("pool_wr_arbiter: push dropped, lanes %b", drop_c);
`else
  logic unused_full_c;

  assign unused_full_c = ^full_vec;
  assign ovf_o         = 1'b0;
`endif

endmodule

// File: tb/tb_pool_wr_arbiter.sv
// Scoreboard bench for pool_wr_arbiter: directed pushes queue expected writes,
// a negedge monitor pops and compares each accepted SRAM write.
module tb_pool_wr_arbiter;
  import pool_pkg::*;

  localparam int unsigned AW_OUT = ADDRESS_WIDTH + LANE_IDX_W;

  typedef struct packed {
    logic              last;
    logic [AW_OUT-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start_i;
  logic                     pool_last_i [POOL_NUM];
  logic [POOL_NUM-1:0]      pool_valid_i;
  logic [DATA_WIDTH-1:0]    pool_result_i [POOL_NUM];
  logic [ADDRESS_WIDTH-1:0] pool_result_address_i [POOL_NUM];
  logic                     wr_valid_o;
  logic                     wr_ready_i;
  logic [AW_OUT-1:0]        wr_addr_o;
  logic [DATA_WIDTH-1:0]    wr_data_o;
  logic                     wr_last_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     ovf_o;

  exp_t exp_q [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   cyc_cnt = 0;
  int   last_acc_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_busy = 1'b0;

  pool_wr_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_i               (start_i),
    .pool_last_i           (pool_last_i),
    .pool_valid_i          (pool_valid_i),
    .pool_result_i         (pool_result_i),
    .pool_result_address_i (pool_result_address_i),
    .wr_valid_o            (wr_valid_o),
    .wr_ready_i            (wr_ready_i),
    .wr_addr_o             (wr_addr_o),
    .wr_data_o             (wr_data_o),
    .wr_last_o             (wr_last_o),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .ovf_o                 (ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_valid_o && wr_ready_i) begin
      acc_cnt++;
      last_acc_cyc = cyc_cnt;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required=none",
                 wr_addr_o, wr_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr_o), 32'(mon_e.addr));
        chk("wr_data", 32'(wr_data_o), 32'(mon_e.data));
        chk("wr_last", 32'(wr_last_o), 32'(mon_e.last));
      end
    end
    if (!rst && done_o) begin
      done_cnt++;
      done_cyc  = cyc_cnt;
      done_busy = busy_o;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    pool_valid_i = '0;
    for (int i = 0; i < int'(POOL_NUM); i++) begin
      pool_last_i[i]           = 1'b0;
      pool_result_i[i]         = '0;
      pool_result_address_i[i] = '0;
    end
  endtask

  task automatic set_lane(input int lane, input logic [DATA_WIDTH-1:0] d,
                          input logic [ADDRESS_WIDTH-1:0] a, input logic l);
    pool_valid_i[lane]          = 1'b1;
    pool_result_i[lane]         = d;
    pool_result_address_i[lane] = a;
    pool_last_i[lane]           = l;
    exp_q.push_back('{last: l, addr: {LANE_IDX_W'(lane), a}, data: d});
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start_i = 1'b0;
    clear_lanes();
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) cyc();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int a0;
    logic exp_ovf;
    wr_ready_i = 1'b1;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    chk("rst_wr_addr",  32'(wr_addr_o),  32'd0);
    chk("rst_wr_data",  32'(wr_data_o),  32'd0);
    chk("rst_wr_last",  32'(wr_last_o),  32'd0);
    chk("rst_busy",     32'(busy_o),     32'd0);
    chk("rst_done",     32'(done_o),     32'd0);
    chk("rst_ovf",      32'(ovf_o),      32'd0);

    // contention: two bursts from all lanes, each drained in lane order 0..15
    for (int b = 0; b < 2; b++) begin
      cyc();
      a0 = acc_cnt;
      for (int i = 0; i < int'(POOL_NUM); i++)
        set_lane(i, 8'(8'h40 + b * 16 + i), 10'(i * 3 + b), 1'b0);
      t0 = cyc_cnt;
      cyc();
      clear_lanes();
      wait_drain("burst_drain", 60);
      chk("burst_count", 32'(acc_cnt - a0), 32'd16);
      chk("burst_span",  32'(last_acc_cyc - t0), 32'd17);
    end

    // single lane latency
    cyc();
    set_lane(5, 8'h3C, 10'h012, 1'b0);
    cyc();
    clear_lanes();
    @(negedge clk);
    chk("lat_t1_valid", 32'(wr_valid_o), 32'd0);
    cyc();
    @(negedge clk);
    chk("lat_t2_valid", 32'(wr_valid_o), 32'd1);
    chk("lat_t2_addr",  32'(wr_addr_o),  32'h1412);
    chk("lat_t2_data",  32'(wr_data_o),  32'h3C);
    wait_drain("single_drain", 10);

    // backpressure: five stalled cycles, then one write
    cyc();
    a0 = acc_cnt;
    wr_ready_i = 1'b0;
    set_lane(9, 8'hA5, 10'h155, 1'b1);
    cyc();
    clear_lanes();
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(wr_valid_o), 32'd1);
      chk("bp_addr",  32'(wr_addr_o),  32'h2555);
      chk("bp_data",  32'(wr_data_o),  32'hA5);
      chk("bp_last",  32'(wr_last_o),  32'd1);
      cyc();
    end
    wr_ready_i = 1'b1;
    wait_drain("bp_drain", 10);
    repeat (3) cyc();
    chk("bp_count", 32'(acc_cnt - a0), 32'd1);

    // overflow: six pushes on lane 2 with ready low, sixth dropped
    a0 = acc_cnt;
    wr_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pool_valid_i[2]          = 1'b1;
      pool_result_i[2]         = 8'(8'h20 + k);
      pool_result_address_i[2] = 10'(10'h100 + k);
      if (k < 5) exp_q.push_back('{last: 1'b0, addr: {LANE_IDX_W'(2), 10'(10'h100 + k)},
                                   data: 8'(8'h20 + k)});
      cyc();
    end
    clear_lanes();
    repeat (2) cyc();
`ifdef POOL_WR_ARB_OVF_CHECK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    chk("ovf_flag",  32'(ovf_o),      32'(exp_ovf));
    chk("ovf_held",  32'(wr_data_o),  32'h20);
    cyc();
    wr_ready_i = 1'b1;
    wait_drain("ovf_drain", 20);
    repeat (4) cyc();
    chk("ovf_count", 32'(acc_cnt - a0), 32'd5);

    // frame: three results per lane, random ready, single done pulse
    do_reset();
    done_cnt = 0;
    a0 = acc_cnt;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    @(negedge clk);
    chk("frame_busy", 32'(busy_o), 32'd1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(POOL_NUM); i++)
        set_lane(i, 8'(i * 16 + r), 10'(r * 64 + i), (r == 2));
      wr_ready_i = 1'($urandom_range(0, 1));
      cyc();
    end
    clear_lanes();
    for (int i = 0; i < 600 && done_cnt == 0; i++) begin
      wr_ready_i = 1'($urandom_range(0, 1));
      cyc();
    end
    wr_ready_i = 1'b1;
    repeat (5) cyc();
    chk("frame_queue",     32'(exp_q.size()),          32'd0);
    chk("frame_writes",    32'(acc_cnt - a0),          32'd48);
    chk("frame_done_cnt",  32'(done_cnt),              32'd1);
    chk("frame_done_time", 32'(done_cyc - last_acc_cyc), 32'd1);
    chk("frame_busy_fall", 32'(done_busy),             32'd0);

    // reset mid-frame with seven entries buffered
    wr_ready_i = 1'b0;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pool_valid_i[i]          = 1'b1;
      pool_result_i[i]         = 8'(8'h70 + i);
      pool_result_address_i[i] = 10'(i);
    end
    cyc();
    clear_lanes();
    repeat (2) cyc();
    @(negedge clk);
    chk("mid_busy_pre",  32'(busy_o),     32'd1);
    chk("mid_valid_pre", 32'(wr_valid_o), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_valid_post", 32'(wr_valid_o), 32'd0);
    chk("mid_busy_post",  32'(busy_o),     32'd0);
    a0 = acc_cnt;
    wr_ready_i = 1'b1;
    repeat (10) cyc();
    chk("mid_no_writes", 32'(acc_cnt - a0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
